// File: rtl/fwd_hazard_pipe_pkg.sv
// Shared types for the ID/EX forwarding and hazard unit: per-stage control
// entry, forwarding-source encoding and the default zero-register index.
package pipeline_pkg;

  localparam int unsigned ZERO_REG_DEFAULT = 31;

  // rd and data live in separate arrays so this struct stays width-independent
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic isload;
  } stage_entry_t;

  typedef enum logic [1:0] {
    SRC_RF,
    SRC_EX,
    SRC_MEM,
    SRC_WB
  } fwd_src_e;

endpackage

// File: rtl/fwd_hazard_pipe_select.sv
// Youngest-first operand select over all tracked stages; falls back to the
// regfile read data when no in-flight instruction writes the source register.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic [REG_W-1:0]  src,
  input  stage_entry_t      ent   [1:DEPTH],
  input  logic [REG_W-1:0]  rd    [1:DEPTH],
  input  logic [DATA_W-1:0] val   [1:DEPTH],
  input  logic [DATA_W-1:0] rf,
  output logic [DATA_W-1:0] data
);

  fwd_src_e          kind;
  logic [DATA_W-1:0] hit_val;

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    kind    = SRC_RF;
    hit_val = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (ent[k].valid && ent[k].regwrite && rd[k] == src &&
          src != REG_W'(ZERO_REG)) begin
        hit_val = val[k];
        if (k == 1)      kind = SRC_EX;
        else if (k == 2) kind = SRC_MEM;
        else             kind = SRC_WB;
      end
    end
    case (kind)
      SRC_RF:  data = rf;
      default: data = hit_val;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_pipe.sv
// Operand forwarding and load-use hazard unit at ID/EX; tracks in-flight
// instructions through writeback and drives the regfile write port.
module fwd_hazard_pipe
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [DATA_W-1:0] rf_da,
  input  logic [DATA_W-1:0] rf_db,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  stage_entry_t      ent    [1:DEPTH];
  logic [REG_W-1:0]  rd_q   [1:DEPTH];
  logic [DATA_W-1:0] data_q [2:DEPTH];
  logic [DATA_W-1:0] val    [1:DEPTH];
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              load_en;

  // Value each stage would forward; stage 1 is still in the ALU this cycle
  always_comb begin
    val[1] = alu_result;
    val[2] = ent[2].isload ? mem_rdata : data_q[2];
    for (int unsigned k = 3; k <= DEPTH; k++) val[k] = data_q[k];
  end

  always_comb begin
    stall = id_valid && !flush && ent[1].valid && ent[1].isload &&
            ent[1].regwrite && rd_q[1] != REG_W'(ZERO_REG) &&
            ((id_use_a && id_rn == rd_q[1]) || (id_use_b && id_rm == rd_q[1]));
  end

  assign load_en = id_valid && !stall && !flush;

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG))
    u_sel_a (.src(id_rn), .ent(ent), .rd(rd_q), .val(val), .rf(rf_da), .data(fwd_a));

  fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG))
    u_sel_b (.src(id_rm), .ent(ent), .rd(rd_q), .val(val), .rf(rf_db), .data(fwd_b));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        ent[k]  <= '0;
        rd_q[k] <= '0;
      end
      for (int unsigned k = 2; k <= DEPTH; k++) data_q[k] <= '0;
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (load_en) begin
        ent[1]  <= '{valid: 1'b1, regwrite: id_regwrite, isload: id_memread};
        rd_q[1] <= id_rd;
        op_a    <= fwd_a;
        op_b    <= fwd_b;
      end else begin
        ent[1] <= '0;
      end
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        ent[k]  <= ent[k-1];
        rd_q[k] <= rd_q[k-1];
      end
      data_q[2] <= alu_result;
      for (int unsigned k = 3; k <= DEPTH; k++) data_q[k] <= val[k-1];
    end
  end

  assign ex_valid = ent[1].valid;
  assign wb_we    = ent[DEPTH].valid && ent[DEPTH].regwrite &&
                    rd_q[DEPTH] != REG_W'(ZERO_REG);
  assign wb_rd    = rd_q[DEPTH];
  assign wb_data  = val[DEPTH];

endmodule
